native_mem_copier: RTL and testbench
====================================

Name: native_mem_copier

Overview:
- Bus initiator on the picorv32 native memory interface: mem_valid, mem_instr, mem_ready, mem_addr, mem_wdata, mem_wstrb, mem_rdata.
- Copies LEN consecutive 32-bit words from a source address to a destination address, one read then one write per word.
- Used as a non-CPU master for loading and relocating memory images, and to exercise memory responders in benches.
- Drives the master side only; the attached memory is the responder.

Parameters:
- LEN_W, 16, width of the word-count input.
- TIMEOUT, 255, maximum mem_valid-high cycles without mem_ready; used only when NATIVE_MEM_COPIER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; one clock domain.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  32  source byte address; bits [1:0] ignored (forced 0).
- dst_addr  in  32  destination byte address; bits [1:0] ignored (forced 0).
- len  in  LEN_W  number of words to copy.
- busy  out  1  high from the cycle after start until the done cycle, inclusive.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky timeout flag; cleared by the next accepted start.
- mem_valid  out  1  transfer request.
- mem_instr  out  1  always 0 (data accesses only).
- mem_ready  in  1  responder completion; may be combinational from mem_valid.
- mem_addr  out  32  word-aligned transfer address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b1111 for writes, 4'b0000 for reads.
- mem_rdata  in  32  read data; valid in the handshake cycle.

Behaviour:
- Reset: on a clk edge with resetn=0, all outputs go to 0 and the FSM goes to IDLE.
  - Applies mid-transfer: mem_valid is 0 from the first reset cycle; no partial state survives.
- FSM states: IDLE, RD, RD_GAP, WR, WR_GAP, DONE.
- IDLE:
  - start=1 with len!=0: latch aligned src/dst and len, clear index and error, go to RD.
  - start=1 with len=0: go to DONE with no bus traffic.
  - start is ignored in every other state.
- Handshake: a transfer completes on a clk edge where mem_valid=1 and mem_ready=1.
  - mem_addr, mem_wdata and mem_wstrb are registered and stable for as long as mem_valid=1.
- RD:
  - mem_valid=1, mem_addr=src+4*i, mem_wstrb=0.
  - On handshake: capture mem_rdata into the word buffer, go to RD_GAP.
- RD_GAP: mem_valid=0 for exactly one cycle, then go to WR.
- WR:
  - mem_valid=1, mem_addr=dst+4*i, mem_wdata=buffer, mem_wstrb=4'b1111.
  - On handshake: i=i+1, go to WR_GAP.
- WR_GAP: mem_valid=0 for one cycle; then go to DONE if i==len, else to RD.
- DONE: done=1 for one cycle, busy=1, then go to IDLE.
- Address arithmetic: 32-bit, wraps modulo 2^32 (src=0xFFFFFFFC, i=1 gives 0x00000000). The index counter is LEN_W bits wide.
- Latency with a zero-wait responder: start at cycle 0 gives the first mem_valid at cycle 1 and the last write handshake at cycle 4*len-1; done is at cycle 4*len.
  - len=0: done at cycle 1.
  - Each responder wait cycle adds one cycle.
- Overlapping regions: copy order is ascending and no hazard handling is provided.

Optional Feature:
- Macro: NATIVE_MEM_COPIER_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle mem_valid=1 and mem_ready=0, and clears on handshake.
  - When the counter reaches TIMEOUT: drop mem_valid the next cycle, set error=1, go to DONE (done pulses), then IDLE.
- Undefined: no counter; error is constant 0; the block waits indefinitely for mem_ready.

Decomposition:
- Shared package native_mem_pkg holds:
  - state enum;
  - WORD_BYTES=4;
  - WSTRB_READ=4'b0000 and WSTRB_FULL=4'b1111;
  - NOP_INSN=32'h00000013, used by benches.
- No sub-module: the watchdog is a small inline counter under the macro.

Test Plan:
- Zero-wait combinational responder; src=0x0, dst=0x100, len=3, source words 0x02100093/0x04100113/0x08100193:
  - reads at 0x0/0x4/0x8 and writes at 0x100/0x104/0x108 with the same data;
  - done at cycle 12, error=0.
- Responder asserting mem_ready 2 cycles after mem_valid, len=2:
  - address and wdata held stable while waiting;
  - done at cycle 4*2+4*2=16;
  - mem_valid low exactly one cycle between transfers.
- len=0 start -> done at cycle 1, busy high only in cycle 1, mem_valid never asserted.
- Second start asserted while busy, len=5 with the first job at len=1 -> ignored; exactly 2 bus transfers, then done.
- resetn=0 during the WR of word 1 -> mem_valid=0, busy=0 and done=0 in the reset cycle; a fresh start afterwards restarts at src.
- Macro defined, TIMEOUT=8, mem_ready tied 0:
  - error=1 and done pulses after 8 stall cycles;
  - the next start clears error.

Source files
------------

// File: rtl/native_mem_pkg.sv
// Shared types and constants for the native-memory copy engine and its benches.
package native_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP,
        DONE
    } state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [3:0]  WSTRB_READ = 4'b0000;
    localparam logic [3:0]  WSTRB_FULL = 4'b1111;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    // Byte address of word idx past base; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/native_mem_copier.sv
// Native-bus copy engine: len words src->dst, one read then one write per word; optional stall watchdog (NATIVE_MEM_COPIER_TIMEOUT_EN).
// Latency: done at cycle 4*len after start with a zero-wait responder (cycle 1 for len=0); +1 cycle per wait cycle.
// Backpressure: holds mem_valid/addr/wdata/wstrb until mem_ready; without the watchdog it waits forever.
module native_mem_copier
    import native_mem_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    state_t           state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] idx_inc;
    logic             stall_expired;

    assign idx_inc   = idx + LEN_W'(1);
    assign mem_instr = 1'b0;

`ifdef NATIVE_MEM_COPIER_TIMEOUT_EN
    logic [31:0] wd_cnt;

    // Fires on the TIMEOUT-th consecutive stalled cycle; mem_valid drops on the next one.
    assign stall_expired = mem_valid && !mem_ready && (wd_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_cnt <= '0;
        end else if (mem_valid && !mem_ready && !stall_expired) begin
            wd_cnt <= wd_cnt + 32'd1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign stall_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= WSTRB_READ;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        busy  <= 1'b1;
                        if (len != '0) begin
                            src_q     <= src_addr & ~32'h3;
                            dst_q     <= dst_addr & ~32'h3;
                            len_q     <= len;
                            idx       <= '0;
                            mem_valid <= 1'b1;
                            mem_addr  <= src_addr & ~32'h3;
                            mem_wstrb <= WSTRB_READ;
                            state     <= RD;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RD: begin
                    if (stall_expired) begin
                        mem_valid <= 1'b0;
                        error     <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (mem_ready) begin
                        // mem_wdata doubles as the word buffer; it is not sampled while mem_valid is low.
                        mem_wdata <= mem_rdata;
                        mem_valid <= 1'b0;
                        state     <= RD_GAP;
                    end
                end
                RD_GAP: begin
                    mem_valid <= 1'b1;
                    mem_addr  <= word_addr(dst_q, 32'(idx));
                    mem_wstrb <= WSTRB_FULL;
                    state     <= WR;
                end
                WR: begin
                    if (stall_expired) begin
                        mem_valid <= 1'b0;
                        error     <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (mem_ready) begin
                        mem_valid <= 1'b0;
                        idx       <= idx_inc;
                        // The final gap cycle is the done cycle itself.
                        if (idx_inc == len_q) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= WR_GAP;
                        end
                    end
                end
                WR_GAP: begin
                    mem_valid <= 1'b1;
                    mem_addr  <= word_addr(src_q, 32'(idx));
                    mem_wstrb <= WSTRB_READ;
                    state     <= RD;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_native_mem_copier.sv
// Directed bench for native_mem_copier against a word-addressed responder with configurable wait states.
module tb_native_mem_copier;
    import native_mem_pkg::*;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, error;
    logic             mem_valid, mem_instr, mem_ready;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [3:0]       mem_wstrb;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    native_mem_copier #(.LEN_W(LEN_W), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .error(error), .mem_valid(mem_valid),
        .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    // Responder: 256-word memory, ready after wait_cfg stalled cycles, transaction log.
    logic [31:0] mem [0:255];
    int          wait_cfg = 0;
    bit          ready_en = 1'b1;
    int          wcnt = 0;
    int          cyc = 0;
    int          log_n = 0;
    logic [31:0] log_addr [0:255];
    logic [31:0] log_data [0:255];
    logic        log_wr   [0:255];

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h0210_0093;
        if (i == 1) return 32'h0410_0113;
        if (i == 2) return 32'h0810_0193;
        return NOP_INSN | (32'(i) << 16);
    endfunction

    assign mem_ready = mem_valid && ready_en && (wcnt >= wait_cfg);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_valid && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (!resetn) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_valid && mem_ready) begin
            log_addr[log_n[7:0]] <= mem_addr;
            log_wr[log_n[7:0]]   <= (mem_wstrb == WSTRB_FULL);
            log_data[log_n[7:0]] <= (mem_wstrb == WSTRB_FULL) ? mem_wdata : mem_rdata;
            log_n <= log_n + 1;
            if (mem_wstrb == WSTRB_FULL) mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench stalled");
    end

    // Pulses start in one cycle (relative cycle 0); returns at the negedge of relative cycle 1.
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l,
                            output int t0);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int budget, output int rel, output logic err);
        rel = -1;
        err = 1'bx;
        for (int k = 0; k < budget; k++) begin
            if (done === 1'b1) begin
                rel = cyc - t0;
                err = error;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if ({mem_valid, busy, done, error} !== 4'b0000) begin
            failed++; $display("FAIL reset_flags: valid/busy/done/error=%b want 0000", {mem_valid, busy, done, error});
        end
        tests++; if ({mem_instr, mem_wstrb, mem_addr} !== 37'd0) begin
            failed++; $display("FAIL reset_bus: instr=%b wstrb=%b addr=%h want 0", mem_instr, mem_wstrb, mem_addr);
        end
        resetn = 1'b1;
        @(negedge clk);
        tests++; if ({mem_valid, busy, done} !== 3'b000) begin
            failed++; $display("FAIL reset_idle: valid/busy/done=%b want 000", {mem_valid, busy, done});
        end
    endtask

    task automatic test_basic_copy();
        int t0, rel, base;
        logic err;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h0210_0093; exp_w[1] = 32'h0410_0113; exp_w[2] = 32'h0810_0193;
        base = log_n;
        do_start(32'h0, 32'h100, 3, t0);
        wait_done(t0, 100, rel, err);
        tests++; if (rel != 12) begin failed++; $display("FAIL basic_done_cycle: got %0d want 12", rel); end
        tests++; if (err !== 1'b0) begin failed++; $display("FAIL basic_error: got %b want 0", err); end
        tests++; if (log_n - base != 6) begin failed++; $display("FAIL basic_xfer_count: got %0d want 6", log_n - base); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (log_addr[base + 2*i] !== 32'(4*i) || log_wr[base + 2*i] !== 1'b0 || log_data[base + 2*i] !== exp_w[i]) begin
                failed++; $display("FAIL basic_read%0d: addr=%h wr=%b data=%h want addr=%h wr=0 data=%h",
                                   i, log_addr[base + 2*i], log_wr[base + 2*i], log_data[base + 2*i], 32'(4*i), exp_w[i]);
            end
            tests++;
            if (log_addr[base + 2*i + 1] !== 32'h100 + 32'(4*i) || log_wr[base + 2*i + 1] !== 1'b1 || log_data[base + 2*i + 1] !== exp_w[i]) begin
                failed++; $display("FAIL basic_write%0d: addr=%h wr=%b data=%h want addr=%h wr=1 data=%h",
                                   i, log_addr[base + 2*i + 1], log_wr[base + 2*i + 1], log_data[base + 2*i + 1], 32'h100 + 32'(4*i), exp_w[i]);
            end
        end
        tests++; if (mem[66] !== 32'h0810_0193) begin failed++; $display("FAIL basic_mem_dst2: got %h want 08100193", mem[66]); end
    endtask

    task automatic test_wait_states();
        int t0, rel, base, unstable, bad_gap, gap;
        logic prev_v, prev_hs, seen_high;
        logic [31:0] prev_a, prev_d;
        logic [3:0] prev_s;
        base = log_n; unstable = 0; bad_gap = 0; gap = 0;
        prev_v = 1'b0; prev_hs = 1'b0; seen_high = 1'b0; prev_a = '0; prev_d = '0; prev_s = '0;
        rel = -1;
        wait_cfg = 2;
        do_start(32'h10, 32'h200, 2, t0);
        for (int k = 0; k < 100; k++) begin
            if (done === 1'b1) begin rel = cyc - t0; break; end
            if (mem_valid) begin
                if (prev_v && !prev_hs && (mem_addr !== prev_a || mem_wdata !== prev_d || mem_wstrb !== prev_s)) unstable++;
                if (prev_v && prev_hs) bad_gap++;
                else if (!prev_v && seen_high && gap != 1) bad_gap++;
                seen_high = 1'b1; gap = 0;
            end else if (seen_high) begin
                gap++;
            end
            prev_v = mem_valid; prev_hs = mem_valid && mem_ready;
            prev_a = mem_addr; prev_d = mem_wdata; prev_s = mem_wstrb;
            @(negedge clk);
        end
        wait_cfg = 0;
        tests++; if (rel != 16) begin failed++; $display("FAIL wait_done_cycle: got %0d want 16", rel); end
        tests++; if (unstable != 0) begin failed++; $display("FAIL wait_stable: %0d changes while stalled, want 0", unstable); end
        tests++; if (bad_gap != 0) begin failed++; $display("FAIL wait_gap: %0d bad gaps, want 0", bad_gap); end
        tests++; if (log_n - base != 4) begin failed++; $display("FAIL wait_xfer_count: got %0d want 4", log_n - base); end
        tests++; if (log_addr[base + 3] !== 32'h204 || log_data[base + 3] !== 32'h0005_0013) begin
            failed++; $display("FAIL wait_write1: addr=%h data=%h want 204/00050013", log_addr[base + 3], log_data[base + 3]);
        end
    endtask

    task automatic test_len_zero();
        int t0, base;
        base = log_n;
        do_start(32'h40, 32'h140, 0, t0);
        tests++; if ({done, busy, mem_valid} !== 3'b110) begin
            failed++; $display("FAIL len0_cycle1: done/busy/valid=%b want 110", {done, busy, mem_valid});
        end
        @(negedge clk);
        tests++; if ({done, busy, mem_valid} !== 3'b000) begin
            failed++; $display("FAIL len0_cycle2: done/busy/valid=%b want 000", {done, busy, mem_valid});
        end
        tests++; if (log_n != base) begin failed++; $display("FAIL len0_traffic: got %0d xfers want 0", log_n - base); end
    endtask

    task automatic test_start_ignored();
        int t0, rel, base;
        logic err;
        base = log_n;
        do_start(32'h20, 32'h280, 1, t0);
        len = 5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(t0, 100, rel, err);
        tests++; if (rel != 4) begin failed++; $display("FAIL ignore_done_cycle: got %0d want 4", rel); end
        repeat (20) @(negedge clk);
        tests++; if (log_n - base != 2 || busy !== 1'b0) begin
            failed++; $display("FAIL ignore_xfers: got %0d xfers busy=%b want 2 busy=0", log_n - base, busy);
        end
        tests++; if (log_addr[base] !== 32'h20 || log_data[base + 1] !== 32'h0008_0013) begin
            failed++; $display("FAIL ignore_data: addr=%h data=%h want 20/00080013", log_addr[base], log_data[base + 1]);
        end
    endtask

    task automatic test_wrap();
        int t0, rel, base;
        logic err;
        base = log_n;
        do_start(32'hFFFF_FFFE, 32'h303, 2, t0);
        wait_done(t0, 100, rel, err);
        tests++; if (rel != 8) begin failed++; $display("FAIL wrap_done_cycle: got %0d want 8", rel); end
        tests++; if (log_addr[base] !== 32'hFFFF_FFFC || log_addr[base + 1] !== 32'h300) begin
            failed++; $display("FAIL wrap_word0: rd=%h wr=%h want FFFFFFFC/300", log_addr[base], log_addr[base + 1]);
        end
        tests++; if (log_addr[base + 2] !== 32'h0 || log_addr[base + 3] !== 32'h304 || log_data[base + 3] !== 32'h0210_0093) begin
            failed++; $display("FAIL wrap_word1: rd=%h wr=%h data=%h want 0/304/02100093",
                               log_addr[base + 2], log_addr[base + 3], log_data[base + 3]);
        end
        tests++; if (mem[192] !== 32'h00FF_0013) begin failed++; $display("FAIL wrap_mem: got %h want 00FF0013", mem[192]); end
    endtask

    task automatic test_reset_mid();
        int t0, rel, base;
        logic err;
        bit found, wrote;
        found = 1'b0; wrote = 1'b0;
        wait_cfg = 3;
        base = log_n;
        do_start(32'h0, 32'h140, 3, t0);
        for (int k = 0; k < 100; k++) begin
            if (mem_valid && mem_wstrb == WSTRB_FULL && mem_addr == 32'h144) begin found = 1'b1; break; end
            @(negedge clk);
        end
        tests++; if (!found) begin failed++; $display("FAIL rstmid_reach_wr1: got not-found want WR at 0x144"); end
        resetn = 1'b0;
        @(negedge clk);
        tests++; if ({mem_valid, busy, done} !== 3'b000) begin
            failed++; $display("FAIL rstmid_outputs: valid/busy/done=%b want 000", {mem_valid, busy, done});
        end
        for (int i = base; i < log_n; i++) if (log_wr[i] && log_addr[i] == 32'h144) wrote = 1'b1;
        tests++; if (wrote) begin failed++; $display("FAIL rstmid_no_write: got write at 0x144 want none"); end
        resetn = 1'b1;
        wait_cfg = 0;
        @(negedge clk);
        base = log_n;
        do_start(32'h0, 32'h140, 1, t0);
        wait_done(t0, 100, rel, err);
        tests++; if (rel != 4 || log_addr[base] !== 32'h0 || log_wr[base] !== 1'b0) begin
            failed++; $display("FAIL rstmid_restart: done=%0d first_addr=%h wr=%b want 4/0/0", rel, log_addr[base], log_wr[base]);
        end
    endtask

`ifdef NATIVE_MEM_COPIER_TIMEOUT_EN
    task automatic test_timeout();
        int t0, rel, hi;
        logic err;
        rel = -1; hi = 0; err = 1'bx;
        ready_en = 1'b0;
        do_start(32'h0, 32'h180, 2, t0);
        for (int k = 0; k < 50; k++) begin
            if (done === 1'b1) begin rel = cyc - t0; err = error; break; end
            if (mem_valid) hi++;
            @(negedge clk);
        end
        tests++; if (rel != 9 || err !== 1'b1) begin failed++; $display("FAIL timeout_done: cycle=%0d error=%b want 9/1", rel, err); end
        tests++; if (hi != 8 || mem_valid !== 1'b0) begin
            failed++; $display("FAIL timeout_valid: high=%0d valid_at_done=%b want 8/0", hi, mem_valid);
        end
        ready_en = 1'b1;
        @(negedge clk);
        tests++; if (error !== 1'b1) begin failed++; $display("FAIL timeout_sticky: got %b want 1", error); end
        do_start(32'h0, 32'h180, 1, t0);
        tests++; if (error !== 1'b0) begin failed++; $display("FAIL timeout_clear: got %b want 0", error); end
        wait_done(t0, 100, rel, err);
        tests++; if (rel != 4 || err !== 1'b0) begin failed++; $display("FAIL timeout_recover: cycle=%0d error=%b want 4/0", rel, err); end
    endtask
`else
    task automatic test_no_timeout();
        int t0, rel;
        logic err;
        ready_en = 1'b0;
        do_start(32'h0, 32'h180, 1, t0);
        repeat (300) @(negedge clk);
        tests++; if ({mem_valid, busy, error} !== 3'b110) begin
            failed++; $display("FAIL stall_hold: valid/busy/error=%b want 110", {mem_valid, busy, error});
        end
        ready_en = 1'b1;
        wait_done(t0, 100, rel, err);
        tests++; if (rel != 304 || err !== 1'b0) begin failed++; $display("FAIL stall_release: cycle=%0d error=%b want 304/0", rel, err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_copy();
        test_wait_states();
        test_len_zero();
        test_start_ignored();
        test_wrap();
        test_reset_mid();
`ifdef NATIVE_MEM_COPIER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
